// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises instruction fetches and byte/half/word loads and stores
// onto the cpu's single byte-wide memory port. The port has a 1-cycle
// synchronous read latency. Addresses whose bits [RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1]
// are 2'b11 are IO.
//
// Ports:
//   clk_in, rst_n_in         clock, asynchronous active-low reset
//   rdy_in                   0 = bus owned by HCI, controller freezes
//   mem_din / mem_dout       read byte (valid the cycle after mem_a) / write byte
//   mem_a, mem_wr            byte address, write strobe
//   io_buffer_full           IO writes must not be issued while high
//   if_valid/if_addr/if_clear/if_done/if_data       fetch channel (4-byte read)
//   ls_valid/ls_wr/ls_size/ls_addr/ls_wdata/ls_done/ls_rdata   load/store channel
module mem_ctrl #(
  parameter int RAM_ADDR_WIDTH = 17
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_valid,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        if_clear,
  input  logic        ls_valid,
  input  logic        ls_wr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE} state_t;

  state_t      state_reg, state_next;
  logic        fetch_reg, fetch_next;          // current read is a fetch (if_clear applies)
  logic [31:0] base_reg, base_next;
  logic [2:0]  len_reg, len_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [2:0]  k_reg, k_next;                  // next byte to issue
  logic        a_valid_reg, a_valid_next;      // mem_a carries read byte a_idx this cycle
  logic [1:0]  a_idx_reg, a_idx_next;
  logic        d_valid_reg, d_valid_next;      // mem_din carries read byte d_idx this cycle
  logic [1:0]  d_idx_reg, d_idx_next;
  logic        redo_reg, redo_next;            // a byte lost to a stall must be re-read
  logic [1:0]  redo_idx_reg, redo_idx_next;
  logic [3:0]  got_reg, got_next;              // bytes received so far
  logic [31:0] rdata_reg, rdata_next;
  logic [31:0] mem_a_reg, mem_a_next;
  logic [7:0]  mem_dout_reg, mem_dout_next;
  logic        mem_wr_reg, mem_wr_next;
  logic        if_done_reg, if_done_next;
  logic [31:0] if_data_reg, if_data_next;
  logic        ls_done_reg, ls_done_next;
  logic [31:0] ls_rdata_reg, ls_rdata_next;

  // request selection: load/store wins over fetch
  logic        req_take, req_fetch, req_wr, req_io;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_len;

  logic [31:0] cur_addr, redo_addr;
  logic        cur_io;
  logic [7:0]  cur_byte;
  logic [3:0]  len_mask, got_v;
  logic [31:0] rdata_v;

  always_comb begin
    req_take  = 1'b0;
    req_fetch = 1'b0;
    req_wr    = 1'b0;
    req_addr  = ls_addr;
    req_wdata = ls_wdata;
    req_len   = 3'd4;
    if (!if_done_reg && !ls_done_reg) begin
      if (ls_valid) begin
        req_take = 1'b1;
        req_wr   = ls_wr;
        req_len  = (ls_size == 2'd0) ? 3'd1 : (ls_size == 2'd1) ? 3'd2 : 3'd4;
      end else if (if_valid && !if_clear) begin
        req_take  = 1'b1;
        req_fetch = 1'b1;
        req_addr  = if_addr;
        req_wdata = 32'd0;
      end
    end
  end

  assign req_io    = (req_addr[RAM_ADDR_WIDTH -: 2] == 2'b11);
  assign cur_addr  = base_reg + {29'd0, k_reg};
  assign redo_addr = base_reg + {30'd0, redo_idx_reg};
  assign cur_io    = (cur_addr[RAM_ADDR_WIDTH -: 2] == 2'b11);
  assign cur_byte  = wdata_reg[{k_reg[1:0], 3'b000} +: 8];
  assign len_mask  = (len_reg == 3'd1) ? 4'b0001 : (len_reg == 3'd2) ? 4'b0011 : 4'b1111;

  always_comb begin
    state_next    = state_reg;
    fetch_next    = fetch_reg;
    base_next     = base_reg;
    len_next      = len_reg;
    wdata_next    = wdata_reg;
    k_next        = k_reg;
    a_valid_next  = a_valid_reg;
    a_idx_next    = a_idx_reg;
    d_valid_next  = d_valid_reg;
    d_idx_next    = d_idx_reg;
    redo_next     = redo_reg;
    redo_idx_next = redo_idx_reg;
    got_next      = got_reg;
    rdata_next    = rdata_reg;
    mem_a_next    = mem_a_reg;
    mem_dout_next = mem_dout_reg;
    mem_wr_next   = mem_wr_reg;
    if_done_next  = if_done_reg;
    if_data_next  = if_data_reg;
    ls_done_next  = ls_done_reg;
    ls_rdata_next = ls_rdata_reg;
    got_v         = got_reg;
    rdata_v       = rdata_reg;

    if (rdy_in) begin
      if_done_next  = 1'b0;
      if_data_next  = 32'd0;
      ls_done_next  = 1'b0;
      ls_rdata_next = 32'd0;
      case (state_reg)
        ST_IDLE: begin
          mem_a_next    = 32'd0;
          mem_wr_next   = 1'b0;
          mem_dout_next = 8'd0;
          if (req_take) begin
            fetch_next   = req_fetch;
            base_next    = req_addr;
            len_next     = req_len;
            wdata_next   = req_wdata;
            got_next     = 4'd0;
            rdata_next   = 32'd0;
            d_valid_next = 1'b0;
            redo_next    = 1'b0;
            if (req_wr) begin
              state_next = ST_WRITE;
              k_next     = 3'd0;
              if (!(req_io && io_buffer_full)) begin
                mem_a_next    = req_addr;
                mem_dout_next = req_wdata[7:0];
                mem_wr_next   = 1'b1;
                k_next        = 3'd1;
              end
            end else begin
              state_next   = ST_READ;
              mem_a_next   = req_addr;
              a_valid_next = 1'b1;
              a_idx_next   = 2'd0;
              k_next       = 3'd1;
            end
          end
        end
        ST_READ: begin
          if (fetch_reg && if_clear) begin
            state_next   = ST_IDLE;
            mem_a_next   = 32'd0;
            a_valid_next = 1'b0;
            d_valid_next = 1'b0;
            redo_next    = 1'b0;
          end else begin
            if (d_valid_reg) begin
              rdata_v[{d_idx_reg, 3'b000} +: 8] = mem_din;
              got_v[d_idx_reg] = 1'b1;
            end
            got_next     = got_v;
            rdata_next   = rdata_v;
            d_valid_next = a_valid_reg;
            d_idx_next   = a_idx_reg;
            if (got_v == len_mask) begin
              state_next   = ST_IDLE;
              mem_a_next   = 32'd0;
              a_valid_next = 1'b0;
              d_valid_next = 1'b0;
              if (fetch_reg) begin
                if_done_next = 1'b1;
                if_data_next = rdata_v;
              end else begin
                ls_done_next  = 1'b1;
                ls_rdata_next = rdata_v;
              end
            end else if (redo_reg) begin
              mem_a_next   = redo_addr;
              a_valid_next = 1'b1;
              a_idx_next   = redo_idx_reg;
              redo_next    = 1'b0;
            end else if (k_reg < len_reg) begin
              mem_a_next   = cur_addr;
              a_valid_next = 1'b1;
              a_idx_next   = k_reg[1:0];
              k_next       = k_reg + 3'd1;
            end else begin
              // all bytes issued; idle address while the last data returns
              mem_a_next   = 32'd0;
              a_valid_next = 1'b0;
            end
          end
        end
        ST_WRITE: begin
          mem_a_next    = 32'd0;
          mem_wr_next   = 1'b0;
          mem_dout_next = 8'd0;
          if (k_reg == len_reg) begin
            state_next   = ST_IDLE;
            ls_done_next = 1'b1;
          end else if (!(cur_io && io_buffer_full)) begin
            mem_a_next    = cur_addr;
            mem_dout_next = cur_byte;
            mem_wr_next   = 1'b1;
            k_next        = k_reg + 3'd1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end else if (state_reg == ST_READ && d_valid_reg) begin
      // frozen: the byte arriving now came from a bus we did not own; re-read it later
      d_valid_next  = 1'b0;
      redo_next     = 1'b1;
      redo_idx_next = d_idx_reg;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg    <= ST_IDLE;
      fetch_reg    <= 1'b0;
      base_reg     <= 32'd0;
      len_reg      <= 3'd0;
      wdata_reg    <= 32'd0;
      k_reg        <= 3'd0;
      a_valid_reg  <= 1'b0;
      a_idx_reg    <= 2'd0;
      d_valid_reg  <= 1'b0;
      d_idx_reg    <= 2'd0;
      redo_reg     <= 1'b0;
      redo_idx_reg <= 2'd0;
      got_reg      <= 4'd0;
      rdata_reg    <= 32'd0;
      mem_a_reg    <= 32'd0;
      mem_dout_reg <= 8'd0;
      mem_wr_reg   <= 1'b0;
      if_done_reg  <= 1'b0;
      if_data_reg  <= 32'd0;
      ls_done_reg  <= 1'b0;
      ls_rdata_reg <= 32'd0;
    end else begin
      state_reg    <= state_next;
      fetch_reg    <= fetch_next;
      base_reg     <= base_next;
      len_reg      <= len_next;
      wdata_reg    <= wdata_next;
      k_reg        <= k_next;
      a_valid_reg  <= a_valid_next;
      a_idx_reg    <= a_idx_next;
      d_valid_reg  <= d_valid_next;
      d_idx_reg    <= d_idx_next;
      redo_reg     <= redo_next;
      redo_idx_reg <= redo_idx_next;
      got_reg      <= got_next;
      rdata_reg    <= rdata_next;
      mem_a_reg    <= mem_a_next;
      mem_dout_reg <= mem_dout_next;
      mem_wr_reg   <= mem_wr_next;
      if_done_reg  <= if_done_next;
      if_data_reg  <= if_data_next;
      ls_done_reg  <= ls_done_next;
      ls_rdata_reg <= ls_rdata_next;
    end
  end

  assign mem_a    = mem_a_reg;
  assign mem_dout = mem_dout_reg;
  // a held write is re-presented on resume, so it lands exactly once
  assign mem_wr   = mem_wr_reg & rdy_in;
  assign if_done  = if_done_reg;
  assign if_data  = if_data_reg;
  assign ls_done  = ls_done_reg;
  assign ls_rdata = ls_rdata_reg;

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, rdy, io_full;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        if_valid, if_done, if_clear;
  logic [31:0] if_addr, if_data;
  logic        ls_valid, ls_wr, ls_done;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;

  int checks = 0;
  int errors = 0;

  bit [7:0] ram [0:262143];
  logic [31:0] la [0:63];
  logic        lw [0:63];
  logic [7:0]  ld [0:63];

  always #5 clk = ~clk;

  // RAM/IO bus model: 1-cycle read latency; HCI owns the bus while rdy is low
  always @(posedge clk) begin
    if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
    mem_din <= rdy ? ram[mem_a[17:0]] : 8'hEE;
  end

  mem_ctrl #(.RAM_ADDR_WIDTH(17)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_full),
    .if_valid(if_valid), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .if_clear(if_clear),
    .ls_valid(ls_valid), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
  );

  typedef struct {
    logic        fetch;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  // issue one request at a negedge, wait for its done, log the bus per cycle
  task automatic run_req(input logic fetch, input logic wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] data, output int lat);
    if (fetch) begin
      if_valid = 1'b1; if_addr = addr;
    end else begin
      ls_valid = 1'b1; ls_wr = wr; ls_size = size; ls_addr = addr; ls_wdata = wdata;
    end
    lat = -1;
    data = 32'd0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      la[k] = mem_a; lw[k] = mem_wr; ld[k] = mem_dout;
      if (fetch ? if_done : ls_done) begin
        lat = k;
        data = fetch ? if_data : ls_rdata;
        break;
      end
    end
    if_valid = 1'b0;
    ls_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] d, got_ls, got_if, first_a, exp_w;
    int lat, ls_at, if_at, wr_cnt, good_cnt, first_wr, done_cnt, bad;

    rst_n = 1'b0; rdy = 1'b1; io_full = 1'b0;
    if_valid = 1'b0; if_addr = 32'd0; if_clear = 1'b0;
    ls_valid = 1'b0; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'd0; ls_wdata = 32'd0;
    ram[32'h100] <= 8'h13; ram[32'h101] <= 8'h05; ram[32'h102] <= 8'h00; ram[32'h103] <= 8'h00;
    ram[32'h10] <= 8'h80;
    ram[32'h300] <= 8'h5A; ram[32'h301] <= 8'hC3;

    vecs[0]  = '{1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'h0,          32'h0000_0513, 6};
    vecs[1]  = '{1'b0, 1'b1, 2'd2, 32'h0000_0200, 32'hDEAD_BEEF,  32'h0,         5};
    vecs[2]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0200, 32'h0,          32'hDEAD_BEEF, 6};
    vecs[3]  = '{1'b0, 1'b0, 2'd1, 32'h0000_0200, 32'h0,          32'h0000_BEEF, 4};
    vecs[4]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0203, 32'h0,          32'h0000_00DE, 3};
    vecs[5]  = '{1'b0, 1'b0, 2'd3, 32'h0000_0200, 32'h0,          32'hDEAD_BEEF, 6};
    vecs[6]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0010, 32'h0,          32'h0000_0080, 3};
    vecs[7]  = '{1'b0, 1'b1, 2'd1, 32'h0000_0305, 32'hFFFF_5678,  32'h0,         3};
    vecs[8]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0304, 32'h0,          32'h0056_7800, 6};
    vecs[9]  = '{1'b0, 1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0000_00AA,  32'h0,         2};
    vecs[10] = '{1'b0, 1'b0, 2'd0, 32'hFFFF_FFFF, 32'h0,          32'h0000_00AA, 3};
    vecs[11] = '{1'b0, 1'b1, 2'd2, 32'hFFFF_FFFE, 32'h1122_3344,  32'h0,         5};
    vecs[12] = '{1'b0, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0,          32'h1122_3344, 6};

    repeat (2) @(negedge clk);
    chk("rst mem_a", mem_a, 32'h0);
    chk("rst mem_wr", {31'd0, mem_wr}, 32'h0);
    chk("rst mem_dout", {24'd0, mem_dout}, 32'h0);
    chk("rst dones", {30'd0, if_done, ls_done}, 32'h0);
    chk("rst data", if_data | ls_rdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // table-driven single transactions
    for (int i = 0; i < 13; i++) begin
      run_req(vecs[i].fetch, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata, d, lat);
      if (!vecs[i].wr) chk($sformatf("vec%0d data", i), d, vecs[i].exp_data);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
    end

    // fetch address sequence
    run_req(1'b1, 1'b0, 2'd2, 32'h100, 32'h0, d, lat);
    for (int i = 1; i <= 4; i++) chk($sformatf("fetch mem_a c+%0d", i), la[i], 32'h100 + 32'(i - 1));
    chk("fetch mem_a c+5 idle", la[5], 32'h0);

    // store byte sequence
    exp_w = 32'hDEAD_BEEF;
    run_req(1'b0, 1'b1, 2'd2, 32'h500, exp_w, d, lat);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("sw mem_wr c+%0d", i), {31'd0, lw[i]}, 32'h1);
      chk($sformatf("sw mem_dout c+%0d", i), {24'd0, ld[i]}, {24'd0, exp_w[8*(i-1) +: 8]});
    end
    chk("sw mem_wr at done", {31'd0, lw[5]}, 32'h0);
    chk("sw ram readback", {ram[32'h503], ram[32'h502], ram[32'h501], ram[32'h500]}, exp_w);

    // simultaneous fetch and load: load first, fetch after ls_done
    ls_valid = 1'b1; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'h10;
    if_valid = 1'b1; if_addr = 32'h100;
    ls_at = -1; if_at = -1; first_a = 32'h0; got_ls = 32'h0; got_if = 32'h0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) first_a = mem_a;
      if (ls_done && ls_at < 0) begin ls_at = k; got_ls = ls_rdata; ls_valid = 1'b0; end
      if (if_done && if_at < 0) begin if_at = k; got_if = if_data; if_valid = 1'b0; break; end
    end
    ls_valid = 1'b0; if_valid = 1'b0;
    @(negedge clk);
    chk("prio first mem_a", first_a, 32'h10);
    chk("prio ls_done cycle", 32'(ls_at), 32'd3);
    chk("prio ls_rdata", got_ls, 32'h80);
    chk("prio if_done cycle", 32'(if_at), 32'd10);
    chk("prio if_data", got_if, 32'h513);

    // IO store stalled by a full write buffer
    io_full = 1'b1;
    ls_valid = 1'b1; ls_wr = 1'b1; ls_size = 2'd0; ls_addr = 32'h30000; ls_wdata = 32'h41;
    wr_cnt = 0; good_cnt = 0; first_wr = -1; ls_at = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (mem_wr) begin
        wr_cnt++;
        if (first_wr < 0) first_wr = k;
        if (mem_dout == 8'h41 && mem_a == 32'h30000) good_cnt++;
      end
      if (k == 3) io_full = 1'b0;
      if (ls_done) begin ls_at = k; break; end
    end
    ls_valid = 1'b0;
    @(negedge clk);
    chk("io write count", 32'(wr_cnt), 32'd1);
    chk("io write content", 32'(good_cnt), 32'd1);
    chk("io write cycle", 32'(first_wr), 32'd4);
    chk("io ls_done cycle", 32'(ls_at), 32'd5);
    chk("io ram", {24'd0, ram[32'h30000]}, 32'h41);

    // fetch aborted by if_clear
    if_valid = 1'b1; if_addr = 32'h100;
    first_a = 32'h0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      first_a = mem_a;
    end
    chk("clear mem_a c+3", first_a, 32'h102);
    if_clear = 1'b1; if_valid = 1'b0;
    @(negedge clk);
    chk("clear mem_a c+4", mem_a, 32'h0);
    if_clear = 1'b0;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (if_done || mem_a != 32'h0) bad++;
    end
    chk("clear quiet cycles", 32'(bad), 32'd0);
    run_req(1'b0, 1'b0, 2'd0, 32'h10, 32'h0, d, lat);
    chk("clear next ls data", d, 32'h80);
    chk("clear next ls latency", 32'(lat), 32'd3);

    // rdy low for two cycles in the middle of a halfword load
    ls_valid = 1'b1; ls_wr = 1'b0; ls_size = 2'd1; ls_addr = 32'h300;
    ls_at = -1; got_ls = 32'h0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (ls_done) begin ls_at = k; got_ls = ls_rdata; break; end
      if (k == 2) rdy = 1'b0;
      if (k == 4) rdy = 1'b1;
    end
    rdy = 1'b1; ls_valid = 1'b0;
    @(negedge clk);
    chk("stall lh data", got_ls, 32'h0000_C35A);
    chk("stall lh done cycle", 32'(ls_at), 32'd7);

    // reset in the middle of a word store
    ls_valid = 1'b1; ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h400; ls_wdata = 32'h0102_0304;
    @(negedge clk);
    chk("rst-mid mem_wr before", {31'd0, mem_wr}, 32'h1);
    @(negedge clk);
    rst_n = 1'b0; ls_valid = 1'b0;
    #1;
    chk("rst-mid mem_wr", {31'd0, mem_wr}, 32'h0);
    chk("rst-mid mem_a", mem_a, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ls_done) done_cnt++;
    end
    chk("rst-mid no done", 32'(done_cnt), 32'd0);
    chk("rst-mid byte0 written", {24'd0, ram[32'h400]}, 32'h04);
    chk("rst-mid byte1 not written", {24'd0, ram[32'h401]}, 32'h00);
    run_req(1'b0, 1'b0, 2'd0, 32'h10, 32'h0, d, lat);
    chk("post-rst load", d, 32'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
